// File: rtl/host_com_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : host_com_driver_if
// Brief    : com_* load/readback bus between the host driver and the processor.
// Revision : 1.0 - initial release
// ============================================================================
interface host_com_driver_if;
    logic [15:0] com_data_in;
    logic        data_write_start;
    logic        data_write_done;
    logic [3:0]  n_cores;
    logic [15:0] com_data_out;
    logic        output_write_start;
    logic        output_write_done;

    modport master (
        output com_data_in, data_write_start, data_write_done, n_cores,
        input  com_data_out, output_write_start, output_write_done
    );

    modport slave (
        input  com_data_in, data_write_start, data_write_done, n_cores,
        output com_data_out, output_write_start, output_write_done
    );
endinterface
`default_nettype wire

// File: rtl/host_com_driver.sv
`default_nettype none
// ============================================================================
// Module   : host_com_driver
// Brief    : Streams the input buffer into the processor and captures the
//            readback burst. Optional WAIT timeout: define HOST_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module host_com_driver #(
    parameter int N_WORDS     = 1024,
    parameter int RES_WORDS   = 1024,
    parameter int RD_SKIP     = 1,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_we,
    input  logic [9:0]        ld_addr,
    input  logic [15:0]       ld_data,
    input  logic [9:0]        rd_addr,
    output logic [15:0]       rd_data,
    input  logic              cmd_start,
    input  logic [3:0]        cmd_n_cores,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [10:0]       res_count,
    host_com_driver_if.master com
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_lead  = 3'd2;
    localparam logic [2:0] c_st_send  = 3'd3;
    localparam logic [2:0] c_st_wait  = 3'd4;
    localparam logic [2:0] c_st_recv  = 3'd5;
    localparam logic [2:0] c_st_done  = 3'd6;

    localparam logic [10:0] c_n_words   = 11'(N_WORDS);
    localparam logic [10:0] c_n_last    = 11'(N_WORDS - 1);
    localparam logic [10:0] c_res_words = 11'(RES_WORDS);
    localparam logic [15:0] c_rd_skip   = 16'(RD_SKIP);
    localparam int          c_ra_w      = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;

    logic [15:0] r_in_buf  [0:1023];
    logic [15:0] r_res_buf [0:RES_WORDS-1];
    logic [15:0] r_rd_data;

    logic [10:0] r_ptr;
    logic [15:0] r_skip;
    logic [10:0] r_res_cnt;
    logic [15:0] r_com_data_in;
    logic        r_dws;
    logic        r_dwd;
    logic [3:0]  r_n_cores;
    logic        r_busy;
    logic        r_done;

    logic        w_accept;
    logic        w_sample;
    logic        w_store;
    logic        w_timeout;
    logic        w_send_nxt;
    logic [15:0] w_com_data_nxt;
    logic        w_dws_nxt;
    logic        w_dwd_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. The WAIT cycle that sees output_write_start is
    // already readback sample 0, so a done in that cycle ends the burst.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (cmd_start) w_state_nxt = c_st_start;
            c_st_start: w_state_nxt = c_st_lead;
            c_st_lead:  w_state_nxt = c_st_send;
            c_st_send:  if (r_ptr == c_n_words) w_state_nxt = c_st_wait;
            c_st_wait: begin
                if (com.output_write_start) begin
                    w_state_nxt = com.output_write_done ? c_st_done : c_st_recv;
                end else if (w_timeout) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_recv:  if (com.output_write_done) w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, computed one cycle ahead so every port is a flop
    // ------------------------------------------------------------------
    always_comb begin
        w_accept       = (r_state == c_st_idle) && cmd_start;
        w_sample       = ((r_state == c_st_wait) && com.output_write_start) ||
                         (r_state == c_st_recv);
        w_store        = w_sample && (r_skip == '0) && (r_res_cnt < c_res_words);
        w_send_nxt     = (w_state_nxt == c_st_send);
        w_com_data_nxt = w_send_nxt ? r_in_buf[r_ptr[9:0]] : '0;
        w_dws_nxt      = (w_state_nxt == c_st_start);
        w_dwd_nxt      = w_send_nxt && (r_ptr == c_n_last);
        w_busy_nxt     = (w_state_nxt != c_st_idle) && (w_state_nxt != c_st_done);
        w_done_nxt     = (w_state_nxt == c_st_done);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_com_data_in <= '0;
            r_dws         <= 1'b0;
            r_dwd         <= 1'b0;
            r_n_cores     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_ptr         <= '0;
            r_skip        <= '0;
            r_res_cnt     <= '0;
        end else begin
            r_com_data_in <= w_com_data_nxt;
            r_dws         <= w_dws_nxt;
            r_dwd         <= w_dwd_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            if (w_accept) begin
                r_n_cores <= cmd_n_cores;
                r_res_cnt <= '0;
                r_ptr     <= '0;
                r_skip    <= c_rd_skip;
            end
            // r_ptr always points at the word to launch on the next cycle
            if (w_send_nxt) begin
                r_ptr <= r_ptr + 11'd1;
            end
            if (w_sample && (r_skip != '0)) begin
                r_skip <= r_skip - 16'd1;
            end
            if (w_store) begin
                r_res_cnt <= r_res_cnt + 11'd1;
            end
        end
    end

    // Buffers carry no reset so they can map onto block RAM.
    always_ff @(posedge clk) begin
        if (ld_we && !r_busy) begin
            r_in_buf[ld_addr] <= ld_data;
        end
        if (w_store) begin
            r_res_buf[r_res_cnt[c_ra_w-1:0]] <= com.com_data_out;
        end
        r_rd_data <= ({1'b0, rd_addr} < c_res_words) ? r_res_buf[rd_addr[c_ra_w-1:0]] : '0;
    end

`ifdef HOST_TIMEOUT_EN
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_tmo;
    logic        r_err;

    assign w_timeout = (r_state == c_st_wait) && !com.output_write_start &&
                       (r_tmo == c_tmo_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_tmo <= (r_state == c_st_wait) ? r_tmo + 16'd1 : '0;
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    // Timeout logic compiled out; parameter kept so both builds share one port map.
    logic [15:0] w_unused_tmo;
    assign w_unused_tmo = 16'(TIMEOUT_CYC);
    assign w_timeout    = 1'b0;
    assign err          = 1'b0;
`endif

    assign rd_data              = r_rd_data;
    assign busy                 = r_busy;
    assign done                 = r_done;
    assign res_count            = r_res_cnt;
    assign com.com_data_in      = r_com_data_in;
    assign com.data_write_start = r_dws;
    assign com.data_write_done  = r_dwd;
    assign com.n_cores          = r_n_cores;

endmodule
`default_nettype wire

// File: tb/tb_host_com_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_host_com_driver
// Brief    : Scoreboard bench: full-size driver plus a 1-word / 16-result one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_host_com_driver;

    localparam int N1 = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT 1 (defaults) and DUT 2 (N_WORDS=1, RES_WORDS=16, TIMEOUT_CYC=100)
    logic        ld_we = 0, ld_we2 = 0;
    logic [9:0]  ld_addr = '0, ld_addr2 = '0, rd_addr = '0, rd_addr2 = '0;
    logic [15:0] ld_data = '0, ld_data2 = '0, rd_data, rd_data2;
    logic        cmd_start = 0, cmd_start2 = 0;
    logic [3:0]  cmd_n_cores = '0, cmd_n_cores2 = '0;
    logic        busy, done, err, busy2, done2, err2;
    logic [10:0] res_count, res_count2;

    host_com_driver_if ifc ();
    host_com_driver_if ifc2 ();

    host_com_driver dut (
        .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .cmd_start(cmd_start),
        .cmd_n_cores(cmd_n_cores), .busy(busy), .done(done), .err(err),
        .res_count(res_count), .com(ifc)
    );

    host_com_driver #(.N_WORDS(1), .RES_WORDS(16), .RD_SKIP(1), .TIMEOUT_CYC(100)) dut2 (
        .clk(clk), .rst(rst), .ld_we(ld_we2), .ld_addr(ld_addr2), .ld_data(ld_data2),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .cmd_start(cmd_start2),
        .cmd_n_cores(cmd_n_cores2), .busy(busy2), .done(done2), .err(err2),
        .res_count(res_count2), .com(ifc2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got nothing, expected an entry (cycle %0d)", name, cyc);
    endfunction

    // Scoreboards
    logic [15:0] tx_q[$];
    logic [15:0] tx2_q[$];
    logic [11:0] done_q[$];
    logic [11:0] done2_q[$];
    logic [16:0] rd_q[$];

    // TX monitor, DUT 1
    int m_ph = 0, m_k = 0, tx_done = 0;
    logic [15:0] tx_e;
    always @(negedge clk) begin
        if (rst) begin
            m_ph <= 0;
            m_k  <= 0;
        end else begin
            case (m_ph)
                0: if (ifc.data_write_start) m_ph <= 1;
                1: begin
                    chk("lead", {ifc.data_write_start, ifc.data_write_done, ifc.com_data_in}, 0);
                    m_ph <= 2;
                    m_k  <= 0;
                end
                2: begin
                    if (tx_q.size() == 0) fail_now("tx_q_empty");
                    else begin
                        tx_e = tx_q.pop_front();
                        chk("tx_word", {ifc.data_write_start, ifc.data_write_done, ifc.com_data_in},
                            {1'b0, 1'(m_k == N1 - 1), tx_e});
                    end
                    m_k <= m_k + 1;
                    if (m_k == N1 - 1) m_ph <= 3;
                end
                default: begin
                    chk("wait_zero", {ifc.data_write_start, ifc.data_write_done, ifc.com_data_in}, 0);
                    m_ph    <= 0;
                    tx_done <= tx_done + 1;
                end
            endcase
        end
    end

    // TX monitor, DUT 2 (single-word job: word 0 and done share a cycle)
    int m2_ph = 0, tx2_done = 0, w2 = 0;
    logic [15:0] tx2_e;
    always @(negedge clk) begin
        if (rst) begin
            m2_ph <= 0;
        end else begin
            case (m2_ph)
                0: if (ifc2.data_write_start) m2_ph <= 1;
                1: begin
                    chk("lead2", {ifc2.data_write_start, ifc2.data_write_done, ifc2.com_data_in}, 0);
                    m2_ph <= 2;
                end
                2: begin
                    if (tx2_q.size() == 0) fail_now("tx2_q_empty");
                    else begin
                        tx2_e = tx2_q.pop_front();
                        chk("tx2_word", {ifc2.data_write_start, ifc2.data_write_done, ifc2.com_data_in},
                            {2'b01, tx2_e});
                    end
                    m2_ph <= 3;
                end
                default: begin
                    chk("wait2_zero", {ifc2.data_write_start, ifc2.data_write_done, ifc2.com_data_in}, 0);
                    m2_ph    <= 0;
                    w2       <= cyc;
                    tx2_done <= tx2_done + 1;
                end
            endcase
        end
    end

    // Done monitors
    logic prev_done = 0, prev_done2 = 0;
    int done_cnt = 0, done2_cnt = 0;
    logic [11:0] d_e, d2_e;
    always @(negedge clk) begin
        if (done) begin
            chk("done_width", prev_done, 0);
            if (done_q.size() == 0) fail_now("done_unexpected");
            else begin
                d_e = done_q.pop_front();
                chk("done_status", {busy, err, res_count}, {1'b0, d_e});
            end
            done_cnt <= done_cnt + 1;
        end
        if (done2) begin
            chk("done2_width", prev_done2, 0);
            if (done2_q.size() == 0) fail_now("done2_unexpected");
            else begin
                d2_e = done2_q.pop_front();
                chk("done2_status", {busy2, err2, res_count2}, {1'b0, d2_e});
            end
            done2_cnt <= done2_cnt + 1;
        end
        prev_done  <= done;
        prev_done2 <= done2;
    end

    // Result-buffer read monitor (1-cycle registered read)
    logic rd_req = 0, rd_v = 0;
    logic [16:0] rd_e;
    always @(posedge clk) rd_v <= rd_req;
    always @(negedge clk) begin
        if (rd_v) begin
            if (rd_q.size() == 0) fail_now("rd_q_empty");
            else begin
                rd_e = rd_q.pop_front();
                chk("rd_data", rd_e[16] ? rd_data2 : rd_data, rd_e[15:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input bit sel, input logic [3:0] nc);
        if (sel) begin cmd_start2 = 1; cmd_n_cores2 = nc; end
        else     begin cmd_start  = 1; cmd_n_cores  = nc; end
        tick();
        cmd_start = 0; cmd_start2 = 0; cmd_n_cores = '0; cmd_n_cores2 = '0;
        @(negedge clk);
        if (sel) chk("start2", {ifc2.data_write_start, ifc2.n_cores, busy2, err2, res_count2},
                     {1'b1, nc, 1'b1, 1'b0, 11'd0});
        else     chk("start", {ifc.data_write_start, ifc.n_cores, busy, err, res_count},
                     {1'b1, nc, 1'b1, 1'b0, 11'd0});
    endtask

    task automatic wait_tx(input bit sel, input int target, input int budget);
        int n = 0;
        while ((sel ? tx2_done : tx_done) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ((sel ? tx2_done : tx_done) < target) fail_now("tx_timeout");
    endtask

    task automatic wait_k(input int target, input int budget);
        int n = 0;
        while (m_k < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (m_k < target) fail_now("word_wait_timeout");
    endtask

    // Processor model: sample 0 is junk, sample i>0 carries base+i-1.
    task automatic readback(input bit sel, input int count, input logic [15:0] base,
                            input logic [15:0] junk);
        for (int i = 0; i < count; i++) begin
            logic [15:0] v;
            v = (i == 0) ? junk : base + 16'(i - 1);
            if (sel) begin
                ifc2.output_write_start = 1; ifc2.com_data_out = v;
                ifc2.output_write_done  = (i == count - 1);
            end else begin
                ifc.output_write_start = 1; ifc.com_data_out = v;
                ifc.output_write_done  = (i == count - 1);
            end
            tick();
        end
        ifc.output_write_done = 0;  ifc.com_data_out = '0;
        ifc2.output_write_done = 0; ifc2.com_data_out = '0;
    endtask

    task automatic rd(input bit sel, input logic [9:0] addr, input logic [15:0] exp);
        rd_addr = addr; rd_addr2 = addr; rd_req = 1;
        rd_q.push_back({sel, exp});
        tick();
        rd_req = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifc.com_data_out = '0;  ifc.output_write_start = 0;  ifc.output_write_done = 0;
        ifc2.com_data_out = '0; ifc2.output_write_start = 0; ifc2.output_write_done = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {ifc.com_data_in, ifc.data_write_start, ifc.data_write_done,
                              ifc.n_cores, busy, done, err, res_count}, 0);
        chk("reset_outputs2", {ifc2.com_data_in, ifc2.data_write_start, ifc2.data_write_done,
                               ifc2.n_cores, busy2, done2, err2, res_count2}, 0);
        rst = 0;
        tick();

        // Load buffers
        for (int i = 0; i < N1; i++) begin
            ld_we = 1; ld_addr = 10'(i); ld_data = 16'hA000 + 16'(i);
            tick();
        end
        ld_we = 0;
        ld_we2 = 1; ld_addr2 = 10'd0; ld_data2 = 16'h1234;
        tick();
        ld_we2 = 0;

        // Job 1: full send, ignored inputs mid-SEND, full readback
        for (int k = 0; k < N1; k++) tx_q.push_back(16'hA000 + 16'(k));
        start_job(0, 4'd4);
        wait_k(101, 300);
        @(posedge clk); #1;
        cmd_start = 1; ld_we = 1; ld_addr = 10'd5; ld_data = 16'hFFFF;
        tick();
        cmd_start = 0; ld_we = 0;
        wait_tx(0, 1, 3000);
        tick();
        done_q.push_back({1'b0, 11'd1024});
        readback(0, 1025, 16'hB000, 16'hDEAD);
        repeat (3) tick();
        chk("done_count", done_cnt, 1);
        chk("res_hold", {busy, res_count}, {1'b0, 11'd1024});
        ifc.output_write_start = 0;
        rd(0, 10'd0, 16'hB000);
        rd(0, 10'd1, 16'hB001);
        rd(0, 10'd511, 16'hB1FF);
        rd(0, 10'd1023, 16'hB3FF);
        repeat (2) tick();

        // Job 2: reset in the middle of SEND
        for (int k = 0; k < N1; k++) tx_q.push_back(16'hA000 + 16'(k));
        start_job(0, 4'd7);
        wait_k(301, 600);
        #2 rst = 1;
        #1;
        chk("async_reset", {ifc.com_data_in, ifc.data_write_start, ifc.data_write_done,
                            ifc.n_cores, busy, done, err, res_count}, 0);
        tx_q.delete();
        repeat (2) tick();
        rst = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("idle_after_reset", {ifc.data_write_start, busy, ifc.n_cores}, 0);

        // Job 3: restart from word 0, short readback
        for (int k = 0; k < N1; k++) tx_q.push_back(16'hA000 + 16'(k));
        start_job(0, 4'd2);
        wait_tx(0, 2, 3000);
        tick();
        done_q.push_back({1'b0, 11'd2});
        readback(0, 3, 16'hD000, 16'hDEAD);
        repeat (3) tick();
        ifc.output_write_start = 0;
        chk("res_count_short", res_count, 2);
        rd(0, 10'd0, 16'hD000);
        rd(0, 10'd1, 16'hD001);
        rd(0, 10'd2, 16'hB002);
        repeat (2) tick();

        // DUT 2 job A: overflow of a 16-entry result buffer
        tx2_q.push_back(16'h1234);
        start_job(1, 4'd1);
        wait_tx(1, 1, 20);
        tick();
        done2_q.push_back({1'b0, 11'd16});
        readback(1, 40, 16'hC000, 16'hDEAD);
        repeat (5) tick();
        chk("overflow_hold", {busy2, res_count2}, {1'b0, 11'd16});
        rd(1, 10'd0, 16'hC000);
        rd(1, 10'd15, 16'hC00F);
        ifc2.output_write_start = 0;
        tick();

        // DUT 2 job B: done on the very first sample
        tx2_q.push_back(16'h1234);
        start_job(1, 4'd3);
        wait_tx(1, 2, 20);
        tick();
        done2_q.push_back({1'b0, 11'd0});
        readback(1, 1, 16'h0000, 16'hBEEF);
        ifc2.output_write_start = 0;
        repeat (3) tick();
        chk("first_sample_done", {busy2, err2, res_count2}, 0);
        rd(1, 10'd0, 16'hC000);
        tick();

`ifdef HOST_TIMEOUT_EN
        // DUT 2 job C: no readback, timeout after 100 WAIT cycles
        tx2_q.push_back(16'h1234);
        start_job(1, 4'd5);
        wait_tx(1, 3, 20);
        done2_q.push_back({1'b1, 11'd0});
        begin
            int n = 0;
            while (!done2 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        chk("timeout_cycles", 64'(cyc - w2), 100);
        tick();
        chk("err_sticky", err2, 1);
        // Job D: accept clears err
        tx2_q.push_back(16'h1234);
        start_job(1, 4'd5);
        wait_tx(1, 4, 20);
        tick();
        done2_q.push_back({1'b0, 11'd1});
        readback(1, 2, 16'hE000, 16'hDEAD);
        ifc2.output_write_start = 0;
        repeat (3) tick();
        rd(1, 10'd0, 16'hE000);
`else
        chk("err_tied_low", {err, err2}, 0);
`endif

        repeat (5) tick();
        chk("queues_drained", tx_q.size() + tx2_q.size() + done_q.size() +
                              done2_q.size() + rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
